mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Two-port request arbiter sitting directly upstream of mem_sys_axil. Merges the instruction-fetch port (read-only)
//  and the data port (read/write, byte enables) onto mem_sys_axil's single addr/data_in/wr/rd/valid/be -> data_out/done
//  interface. Round-robin or fixed data priority; returns read data and a one-cycle done to the granted requester only.
//  Includes a watchdog that flags a downstream transaction that never completes.
// PARAMETERS
//  XLEN        32   data width (from defines package)
//  ADDR_W      32   address width, matches cache_addr_t
//  FIX_PRI     0    0 = round-robin between ports; 1 = data port always wins ties
//  TIMEOUT_CYC 255  cycles in WAIT without downstream done before err_timeout sets; 0 disables watchdog
// PORTS
//  clk          in   1       system clock (same clock as mem_sys_axil)
//  rst          in   1       synchronous reset, active-high
//  i_valid      in   1       ifetch request, held high until i_done
//  i_addr       in   ADDR_W   ifetch address, stable while i_valid
//  i_data       out  XLEN     ifetch read data, valid when i_done
//  i_done       out  1       one-cycle completion pulse to ifetch port
//  d_valid      in   1       data request, held high until d_done
//  d_wr         in   1       1 = write, 0 = read; stable while d_valid
//  d_addr       in   ADDR_W   data address
//  d_wdata      in   XLEN     write data
//  d_be         in   4       byte enables for writes (reads issued with 4'b1111)
//  d_rdata      out  XLEN     data read result, valid when d_done
//  d_done       out  1       one-cycle completion pulse to data port
//  m_addr       out  ADDR_W   -> mem_sys_axil addr
//  m_data_in    out  XLEN     -> mem_sys_axil data_in
//  m_wr, m_rd   out  1 each  -> mem_sys_axil wr / rd (never both high)
//  m_valid      out  1       -> mem_sys_axil valid
//  m_be         out  4       -> mem_sys_axil be
//  m_data_out   in   XLEN     <- mem_sys_axil data_out
//  m_done       in   1       <- mem_sys_axil done
//  err_timeout  out  1       sticky watchdog flag, cleared only by rst
// BEHAVIOUR
//  - Reset (rst high at clk edge): state IDLE; all outputs 0 (m_valid, m_wr, m_rd, m_be, m_addr, i/d_done, data, err); last_grant = IFETCH.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//    IDLE: if any *_valid, pick winner, register its addr/wdata/be/wr into m_* regs, go ISSUE. Requests sampled registered; no comb path from *_valid to m_*.
//    ISSUE: m_valid=1 and m_rd/m_wr per winner; go WAIT next cycle.
//    WAIT: hold m_* stable; on m_done=1 capture m_data_out into winner's rdata reg, drop m_valid/m_wr/m_rd the same edge, go RESP.
//    RESP: pulse winner's *_done for exactly one cycle; update last_grant; m_valid low >=1 cycle (mem_sys_axil needs valid deasserted between ops); go IDLE.
//  - Minimum issue-to-issue spacing: 4 cycles + downstream latency. i_done/d_done never high together.
//  - Arbitration: both valid in IDLE -> FIX_PRI=1: data port; FIX_PRI=0: port not equal to last_grant. Single valid -> that port.
//  - Requester dropping *_valid after grant: transaction still completes downstream (cannot abort mem_sys_axil); *_done still pulsed, requester ignores.
//  - m_done high in any state other than WAIT: ignored.
//  - Watchdog: 8-bit counter (width clog2(TIMEOUT_CYC+1)) cleared on entering WAIT, increments each WAIT cycle, saturates; reaching TIMEOUT_CYC sets err_timeout. FSM keeps waiting (no forced release).
//  - rst mid-transaction: FSM to IDLE, m_valid dropped immediately; no *_done for the aborted request.
//  - i_data/d_rdata hold last captured value until next completion on that port.
// STRUCTURE
//  - Shared package mem_defines: typedef arb_state_t {IDLE, ISSUE, WAIT, RESP}; typedef arb_port_t {PORT_I, PORT_D}; localparam BE_FULL = 4'b1111.
//  - One natural sub-module: mem_rr_picker (2-input round-robin/fixed-priority chooser: req[1:0], last, fix_pri -> grant). Rest in one always_ff FSM.
// TESTING (bench: mem_req_arbiter -> mem_sys_axil -> axil_ram, as used by the existing mem_sys bench)
//  1 Reset: hold rst 3 cycles with d_valid=1 -> all m_* and *_done stay 0; err_timeout=0.
//  2 Data write 0xDEADBEEF @0x0000_0040, then ifetch @0x0000_0040 -> i_data=0xDEADBEEF, exactly one i_done pulse, d_done untouched.
//  3 i_valid and d_valid rise same cycle, FIX_PRI=0, last_grant=IFETCH -> data served first, then ifetch; 20 back-to-back pairs alternate strictly.
//  4 FIX_PRI=1, both ports continuously valid -> data port starves ifetch; grant count data=N, ifetch=0 while d_valid stays high.
//  5 Byte write d_be=4'b0010, d_wdata=0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
//  6 Stub m_done stuck 0, TIMEOUT_CYC=16 -> err_timeout sets 16 cycles after WAIT entry and stays set; rst in WAIT returns FSM to IDLE, m_valid=0 next cycle, no *_done.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the two-port memory request arbiter: FSM states, port ids
// and the full byte-enable mask used for every read.
package mem_req_arbiter_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

  localparam logic [3:0] BE_FULL = 4'b1111;

  function automatic arb_port_t other_port(input arb_port_t p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// Two-input chooser: a single requester always wins; on a tie either the data
// port wins (fixed priority) or the port that was not granted last time wins.
module mem_req_arbiter_rr_picker
  import mem_req_arbiter_pkg::*;
(
  input  logic [1:0] req_i,      // [0] = ifetch, [1] = data
  input  arb_port_t  last_i,
  input  logic       fix_pri_i,
  output arb_port_t  grant_o
);

  // Grant selection; an idle request vector defaults to ifetch and is never used
  always_comb begin
    grant_o = PORT_I;
    case (req_i)
      2'b01:   grant_o = PORT_I;
      2'b10:   grant_o = PORT_D;
      2'b11:   grant_o = fix_pri_i ? PORT_D : other_port(last_i);
      default: grant_o = PORT_I;
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges the ifetch and data request ports onto the single mem_sys_axil
// handshake, with a sticky watchdog for transactions that never complete.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int FIX_PRI     = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [XLEN-1:0]   i_data,
  output logic              i_done,
  input  logic              d_valid,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [3:0]        d_be,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] m_addr,
  output logic [XLEN-1:0]   m_data_in,
  output logic              m_wr,
  output logic              m_rd,
  output logic              m_valid,
  output logic [3:0]        m_be,
  input  logic [XLEN-1:0]   m_data_out,
  input  logic              m_done,
  output logic              err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  arb_state_t        state_q, state_d;
  arb_port_t         last_q, last_d, winner_q, winner_d, grant_s;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [XLEN-1:0]   m_wdata_q, m_wdata_d, i_data_q, i_data_d, d_rdata_q, d_rdata_d;
  logic [3:0]        m_be_q, m_be_d;
  logic              m_valid_q, m_valid_d, m_wr_q, m_wr_d, m_rd_q, m_rd_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d, err_q, err_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

  mem_req_arbiter_rr_picker u_picker (
    .req_i     ({d_valid, i_valid}),
    .last_i    (last_q),
    .fix_pri_i (FIX_PRI != 0),
    .grant_o   (grant_s)
  );

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT/RESP sequence
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    winner_d  = winner_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    m_valid_d = m_valid_q;
    m_wr_d    = m_wr_q;
    m_rd_d    = m_rd_q;
    i_data_d  = i_data_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    wd_cnt_d  = wd_cnt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (i_valid || d_valid) begin
          state_d   = ISSUE;
          winner_d  = grant_s;
          m_valid_d = 1'b1;
          if (grant_s == PORT_D) begin
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_wr ? d_be : BE_FULL;
            m_wr_d    = d_wr;
            m_rd_d    = ~d_wr;
          end else begin
            m_addr_d  = i_addr;
            m_wdata_d = {XLEN{1'b0}};
            m_be_d    = BE_FULL;
            m_wr_d    = 1'b0;
            m_rd_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d  = WAIT;
        wd_cnt_d = {CNT_W{1'b0}};
      end
      WAIT: begin
        if (m_done) begin
          state_d   = RESP;
          m_valid_d = 1'b0;
          m_wr_d    = 1'b0;
          m_rd_d    = 1'b0;
          if (winner_q == PORT_D) begin
            d_rdata_d = m_data_out;
            d_done_d  = 1'b1;
          end else begin
            i_data_d  = m_data_out;
            i_done_d  = 1'b1;
          end
        end else begin
          // Saturating count; the FSM keeps waiting even after the flag sets
          if (wd_cnt_q != CNT_MAX) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
          end else begin
            wd_cnt_d = wd_cnt_q;
          end
          if ((TIMEOUT_CYC != 0) && (wd_cnt_d == CNT_MAX)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
      end
      RESP: begin
        last_d  = winner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= PORT_I;
      winner_q  <= PORT_I;
      m_addr_q  <= {ADDR_W{1'b0}};
      m_wdata_q <= {XLEN{1'b0}};
      m_be_q    <= 4'b0000;
      m_valid_q <= 1'b0;
      m_wr_q    <= 1'b0;
      m_rd_q    <= 1'b0;
      i_data_q  <= {XLEN{1'b0}};
      d_rdata_q <= {XLEN{1'b0}};
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      wd_cnt_q  <= {CNT_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      winner_q  <= winner_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      m_valid_q <= m_valid_d;
      m_wr_q    <= m_wr_d;
      m_rd_q    <= m_rd_d;
      i_data_q  <= i_data_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      wd_cnt_q  <= wd_cnt_d;
      err_q     <= err_d;
    end
  end

  assign i_data      = i_data_q;
  assign i_done      = i_done_q;
  assign d_rdata     = d_rdata_q;
  assign d_done      = d_done_q;
  assign m_addr      = m_addr_q;
  assign m_data_in   = m_wdata_q;
  assign m_wr        = m_wr_q;
  assign m_rd        = m_rd_q;
  assign m_valid     = m_valid_q;
  assign m_be        = m_be_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: a behavioural memory stub downstream, a table of
// directed transactions, a transaction-level reference model for random traffic.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, d_valid = 1'b0, d_wr = 1'b0;
  logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] i_data, d_rdata, m_addr, m_data_in, m_data_out;
  logic        i_done, d_done, m_wr, m_rd, m_valid, m_done, err_timeout;
  logic [3:0]  m_be;
  logic        rsp_done, inj_done = 1'b0, stuck = 1'b0, rsp_busy;
  int          rsp_cnt;
  logic [31:0] ram [0:63];

  // Fixed-priority instance with its own trivial responder
  logic        f_i_valid = 1'b0, f_d_valid = 1'b0;
  logic [31:0] f_i_data, f_d_rdata, f_m_addr, f_m_data_in;
  logic        f_i_done, f_d_done, f_m_wr, f_m_rd, f_m_valid, f_m_done, f_err, f_busy;
  logic [3:0]  f_m_be;

  int          n_chk = 0, n_err = 0;
  logic [31:0] ref_mem [0:63];
  logic        model_last;   // 0 = ifetch served last, 1 = data

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, wd;
    logic [3:0]  be;
    logic        efd;
    logic [31:0] ei, ed;
  } vec_t;
  vec_t tbl [10];

  always #5 clk = ~clk;
  assign m_done = rsp_done | inj_done;

  mem_req_arbiter #(.XLEN(32), .ADDR_W(32), .FIX_PRI(0), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_data(i_data), .i_done(i_done),
    .d_valid(d_valid), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_wr(m_wr), .m_rd(m_rd), .m_valid(m_valid),
    .m_be(m_be), .m_data_out(m_data_out), .m_done(m_done), .err_timeout(err_timeout)
  );

  mem_req_arbiter #(.XLEN(32), .ADDR_W(32), .FIX_PRI(1), .TIMEOUT_CYC(255)) u_dut_fp (
    .clk(clk), .rst(rst),
    .i_valid(f_i_valid), .i_addr(32'h0000_0010), .i_data(f_i_data), .i_done(f_i_done),
    .d_valid(f_d_valid), .d_wr(1'b0), .d_addr(32'h0000_0020), .d_wdata(32'h0), .d_be(4'hF),
    .d_rdata(f_d_rdata), .d_done(f_d_done),
    .m_addr(f_m_addr), .m_data_in(f_m_data_in), .m_wr(f_m_wr), .m_rd(f_m_rd), .m_valid(f_m_valid),
    .m_be(f_m_be), .m_data_out(32'h0), .m_done(f_m_done), .err_timeout(f_err)
  );

  function automatic logic [31:0] init_word(input int k);
    return (32'(k) * 32'h0103_0507) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, new_w, input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Downstream memory stub: starts on valid, answers after 0..3 extra cycles
  always @(posedge clk) begin
    rsp_done <= 1'b0;
    if (rst) begin
      rsp_busy   <= 1'b0;
      m_data_out <= 32'h0;
      for (int k = 0; k < 64; k++) ram[k] <= init_word(k);
    end else if (rsp_busy) begin
      if (rsp_cnt == 0) begin
        rsp_busy <= 1'b0;
        rsp_done <= 1'b1;
        if (m_wr) begin
          ram[m_addr[7:2]] <= merge(ram[m_addr[7:2]], m_data_in, m_be);
          m_data_out <= 32'h0;
        end else begin
          m_data_out <= ram[m_addr[7:2]];
        end
      end else begin
        rsp_cnt <= rsp_cnt - 1;
      end
    end else if (m_valid && !m_done && !stuck) begin
      rsp_busy <= 1'b1;
      rsp_cnt  <= int'($urandom_range(0, 3));
    end
  end

  // Responder for the fixed-priority instance
  always @(posedge clk) begin
    f_m_done <= 1'b0;
    if (rst) f_busy <= 1'b0;
    else if (f_busy) begin
      f_busy   <= 1'b0;
      f_m_done <= 1'b1;
    end else if (f_m_valid && !f_m_done) f_busy <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Downstream protocol: exactly one of wr/rd while valid, full enables on reads
  always @(negedge clk) begin
    if (!rst && m_valid === 1'b1) begin
      chk("m_wr_xor_m_rd", {31'b0, m_wr ^ m_rd}, 32'd1);
      if (m_rd === 1'b1) chk("read_be_full", {28'b0, m_be}, 32'hF);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; i_valid = 1'b0; d_valid = 1'b0; f_i_valid = 1'b0; f_d_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    model_last = 1'b0;
  endtask

  // Reference: order from the arbitration rule, data from a flat word array
  task automatic model_txn(input logic ir, dr, dw, input logic [31:0] ia, da, wd,
                           input logic [3:0] be, output logic efd, output logic [31:0] ei, ed);
    logic port;
    efd = (ir && dr) ? ~model_last : dr;
    ei = 32'h0; ed = 32'h0;
    for (int s = 0; s < 2; s++) begin
      port = (s == 0) ? efd : ~efd;
      if (port && dr) begin
        if (dw) ref_mem[da[7:2]] = merge(ref_mem[da[7:2]], wd, be);
        else    ed = ref_mem[da[7:2]];
        model_last = 1'b1;
      end else if (!port && ir) begin
        ei = ref_mem[ia[7:2]];
        model_last = 1'b0;
      end
    end
  endtask

  task automatic run_txn(input logic ir, dr, dw, input logic [31:0] ia, da, wd, input logic [3:0] be,
                         output logic first_d, output logic [31:0] gi, gd);
    int ni, nd, cyc;
    logic seen;
    i_valid = ir; i_addr = ia; d_valid = dr; d_wr = dw; d_addr = da; d_wdata = wd; d_be = be;
    ni = 0; nd = 0; cyc = 0; seen = 1'b0; first_d = 1'b0; gi = 32'h0; gd = 32'h0;
    while ((i_valid || d_valid) && cyc < 200) begin
      tick();
      cyc++;
      chk("done_exclusive", {31'b0, i_done & d_done}, 32'd0);
      if (i_done) begin
        ni++; gi = i_data; i_valid = 1'b0;
        if (!seen) begin first_d = 1'b0; seen = 1'b1; end
      end
      if (d_done) begin
        nd++; gd = d_rdata; d_valid = 1'b0;
        if (!seen) begin first_d = 1'b1; seen = 1'b1; end
      end
    end
    chk("txn_completes", {31'b0, i_valid | d_valid}, 32'd0);
    i_valid = 1'b0; d_valid = 1'b0;
    repeat (3) begin
      tick();
      if (i_done) ni++;
      if (d_done) nd++;
    end
    chk("i_done_pulses", ni, {31'b0, ir});
    chk("d_done_pulses", nd, {31'b0, dr});
  endtask

  initial begin
    logic        gf, efd, seen;
    logic [31:0] gi, gd, ei, ed, ia, da, wd;
    logic        ir, dr, dw;
    logic [3:0]  be;
    int          k, cyc, nd, ni;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h80, 32'h11223344, 4'hF, 1'b1, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h80, 32'h0000AB00, 4'h2, 1'b1, 32'h0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h0, 32'h1122AB44};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h80, 32'h40, 32'h0, 4'h0, 1'b0, 32'h1122AB44, 32'hDEADBEEF};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h40, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, 32'hDEADBEEF, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h0, 32'h1122AB44};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 32'h0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 32'h80, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1122AB44, 32'hCAFEF00D};

    // Reset held with a pending data request: nothing may leave the block
    rst = 1'b1; d_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("reset_outputs", {19'b0, m_valid, m_wr, m_rd, m_be, i_done, d_done, err_timeout,
                            |m_addr, |m_data_in, |i_data, |d_rdata}, 32'h0);
    end
    do_reset(1);

    for (int t = 0; t < 10; t++) begin
      model_txn(tbl[t].ir, tbl[t].dr, tbl[t].dw, tbl[t].ia, tbl[t].da, tbl[t].wd, tbl[t].be, efd, ei, ed);
      run_txn(tbl[t].ir, tbl[t].dr, tbl[t].dw, tbl[t].ia, tbl[t].da, tbl[t].wd, tbl[t].be, gf, gi, gd);
      if (tbl[t].ir && tbl[t].dr) chk($sformatf("tbl%0d_first", t), {31'b0, gf}, {31'b0, tbl[t].efd});
      if (tbl[t].ir) chk($sformatf("tbl%0d_i_data", t), gi, tbl[t].ei);
      if (tbl[t].dr && !tbl[t].dw) chk($sformatf("tbl%0d_d_rdata", t), gd, tbl[t].ed);
    end

    // Stray m_done while idle must be ignored
    inj_done = 1'b1; tick(); inj_done = 1'b0;
    nd = 0;
    repeat (3) begin tick(); nd += int'(i_done) + int'(d_done) + int'(m_valid); end
    chk("idle_m_done_ignored", nd, 32'd0);

    // Ifetch drops valid right after grant: still completes, d_rdata holds
    i_addr = 32'h80; i_valid = 1'b1; tick(); i_valid = 1'b0;
    seen = 1'b0; cyc = 0; gi = 32'h0;
    while (!seen && cyc < 50) begin tick(); cyc++; if (i_done) begin seen = 1'b1; gi = i_data; end end
    chk("dropped_valid_done", {31'b0, seen}, 32'd1);
    chk("dropped_valid_data", gi, 32'h1122AB44);
    chk("d_rdata_holds", d_rdata, 32'hCAFEF00D);
    repeat (2) tick();

    // Both ports held valid from reset: strict alternation starting with data
    do_reset(2);
    i_addr = 32'h40; d_addr = 32'h80; d_wr = 1'b0; i_valid = 1'b1; d_valid = 1'b1;
    k = 0; cyc = 0;
    while (k < 40 && cyc < 600) begin
      tick(); cyc++;
      chk("alt_done_exclusive", {31'b0, i_done & d_done}, 32'd0);
      if (i_done || d_done) begin
        chk($sformatf("alt_order_%0d", k), {31'b0, d_done}, {31'b0, (k % 2) == 0});
        k++;
      end
    end
    chk("alt_count", k, 32'd40);
    i_valid = 1'b0; d_valid = 1'b0;
    repeat (3) tick();

    // Random traffic against the transaction-level model
    do_reset(2);
    for (int t = 0; t < 60; t++) begin
      ir = 1'($urandom_range(0, 1));
      dr = ir ? 1'($urandom_range(0, 1)) : 1'b1;
      dw = 1'($urandom_range(0, 1));
      ia = 32'h0000_00C0 + (32'($urandom_range(0, 15)) << 2);
      da = 32'h0000_00C0 + (32'($urandom_range(0, 15)) << 2);
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      model_txn(ir, dr, dw, ia, da, wd, be, efd, ei, ed);
      run_txn(ir, dr, dw, ia, da, wd, be, gf, gi, gd);
      if (ir && dr) chk("rand_order", {31'b0, gf}, {31'b0, efd});
      if (ir) chk("rand_i_data", gi, ei);
      if (dr && !dw) chk("rand_d_rdata", gd, ed);
    end
    chk("no_spurious_timeout", {31'b0, err_timeout}, 32'd0);

    // Fixed priority: data port continuously valid starves ifetch
    do_reset(2);
    f_i_valid = 1'b1; f_d_valid = 1'b1; nd = 0; ni = 0; cyc = 0;
    while (nd < 10 && cyc < 200) begin
      tick(); cyc++;
      if (f_d_done) nd++;
      if (f_i_done) ni++;
    end
    chk("fixpri_data_grants", nd, 32'd10);
    chk("fixpri_ifetch_grants", ni, 32'd0);
    f_d_valid = 1'b0; cyc = 0;
    while (ni == 0 && cyc < 50) begin tick(); cyc++; if (f_i_done) ni++; end
    chk("fixpri_ifetch_after_release", ni, 32'd1);
    f_i_valid = 1'b0;

    // Watchdog: stuck downstream, flag 16 cycles after WAIT entry, then reset in WAIT
    do_reset(2);
    stuck = 1'b1; d_addr = 32'h40; d_wr = 1'b0; d_valid = 1'b1;
    tick();
    tick();
    repeat (15) tick();
    chk("wd_not_yet", {31'b0, err_timeout}, 32'd0);
    tick();
    chk("wd_set", {31'b0, err_timeout}, 32'd1);
    repeat (5) tick();
    chk("wd_sticky", {31'b0, err_timeout}, 32'd1);
    chk("wd_still_waiting", {31'b0, m_valid}, 32'd1);
    rst = 1'b1; d_valid = 1'b0;
    tick();
    chk("rst_in_wait_m_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_clears_err", {31'b0, err_timeout}, 32'd0);
    rst = 1'b0; stuck = 1'b0; nd = 0;
    repeat (6) begin tick(); nd += int'(i_done) + int'(d_done); end
    chk("aborted_no_done", nd, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
